// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller interface: debounced button levels in, display and
// status out. The master side (buttons / observer) drives the buttons; the
// slave side (the controller) drives the display and status flags.
interface stopwatch_ctrl_if;
  logic        btn_toggle;
  logic        btn_clr;
  logic [15:0] digits;
  logic        running;
  logic        lap_active;
  logic        overflow;

  modport master (
    output btn_toggle, btn_clr,
    input  digits, running, lap_active, overflow
  );

  modport slave (
    input  btn_toggle, btn_clr,
    output digits, running, lap_active, overflow
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop on every toggle flip, lap/clear on the
// rising edge of btn_clr. Keeps a 4-digit BCD SS.hh count with lap freeze and
// a sticky overflow flag set when 99.99 wraps to 00.00.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 10
) (
  input  logic     clk_1kHz,
  input  logic     rst,
  stopwatch_ctrl_if.slave sw
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  localparam logic [7:0] PRESC_LAST = 8'(TICK_DIV - 1);

  state_t      state_reg, state_next;
  logic        armed_reg;
  logic        tog_q, clr_q;
  logic [7:0]  presc_reg, presc_next;
  logic [15:0] live_reg, live_next;
  logic [15:0] lap_reg, lap_next;
  logic        lap_on_reg, lap_on_next;
  logic        overflow_reg, overflow_next;

  logic        tog_evt, clr_evt;
  logic [15:0] live_inc;
  logic [4:0]  carry;

  // Events only once armed, so a button already high at reset release is quiet.
  assign tog_evt = armed_reg & (sw.btn_toggle != tog_q);
  assign clr_evt = armed_reg & sw.btn_clr & ~clr_q;

  // BCD ripple increment of the live count; carry[4] marks the 99.99 wrap.
  assign carry[0] = 1'b1;
  for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
    logic [3:0] dig;
    assign dig = live_reg[gi*4 +: 4];
    assign live_inc[gi*4 +: 4] = carry[gi] ? ((dig == 4'd9) ? 4'd0 : dig + 4'd1) : dig;
    assign carry[gi+1] = carry[gi] & (dig == 4'd9);
  end

  // Edge-detect history and the arming flag for the first cycle after reset.
  always_ff @(posedge clk_1kHz or posedge rst) begin
    if (rst) begin
      armed_reg <= 1'b0;
      tog_q     <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      armed_reg <= 1'b1;
      tog_q     <= sw.btn_toggle;
      clr_q     <= sw.btn_clr;
    end
  end

  // State, prescaler, live count, lap capture and overflow registers.
  always_ff @(posedge clk_1kHz or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      presc_reg    <= 8'd0;
      live_reg     <= 16'd0;
      lap_reg      <= 16'd0;
      lap_on_reg   <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      presc_reg    <= presc_next;
      live_reg     <= live_next;
      lap_reg      <= lap_next;
      lap_on_reg   <= lap_on_next;
      overflow_reg <= overflow_next;
    end
  end

  // Next-state logic; a toggle event takes priority and swallows a same-cycle clear.
  always_comb begin
    state_next    = state_reg;
    presc_next    = presc_reg;
    live_next     = live_reg;
    lap_next      = lap_reg;
    lap_on_next   = lap_on_reg;
    overflow_next = overflow_reg;

    // Counting only while running; the cycle that leaves RUN holds everything.
    if (state_reg == RUN && !tog_evt) begin
      if (presc_reg == PRESC_LAST) begin
        presc_next = 8'd0;
        live_next  = live_inc;
        if (carry[4]) overflow_next = 1'b1;
      end else begin
        presc_next = presc_reg + 8'd1;
      end
    end

    case (state_reg)
      IDLE: begin
        if (tog_evt) begin
          state_next = RUN;
          presc_next = 8'd0;
        end
      end
      RUN: begin
        if (tog_evt) begin
          state_next = PAUSED;
        end else if (clr_evt) begin
          if (lap_on_reg) begin
            lap_on_next = 1'b0;
          end else begin
            lap_next    = live_reg;
            lap_on_next = 1'b1;
          end
        end
      end
      PAUSED: begin
        if (tog_evt) begin
          state_next = RUN;
        end else if (clr_evt) begin
          if (lap_on_reg) begin
            lap_on_next = 1'b0;
          end else begin
            live_next     = 16'd0;
            presc_next    = 8'd0;
            overflow_next = 1'b0;
            state_next    = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign sw.digits     = lap_on_reg ? lap_reg : live_reg;
  assign sw.running    = (state_reg == RUN);
  assign sw.lap_active = lap_on_reg;
  assign sw.overflow   = overflow_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a driver applies button levels each cycle and
// pushes the reference model's expected outputs into a queue; a monitor pops
// and compares after every rising edge. The model counts time as an integer
// number of hundredths and converts to BCD arithmetically.
module tb_stopwatch_ctrl;
  localparam int DIV = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2;

  logic clk_1kHz = 1'b0;
  logic rst = 1'b1;

  stopwatch_ctrl_if sw();

  stopwatch_ctrl #(.TICK_DIV(DIV)) dut (
    .clk_1kHz(clk_1kHz),
    .rst(rst),
    .sw(sw.slave)
  );

  always #5 clk_1kHz = ~clk_1kHz;

  int total = 0;
  int bad = 0;
  logic [18:0] exp_q[$];

  // reference model state
  int m_st, m_pre, m_live, m_lap;
  bit m_armed, m_tq, m_cq, m_lapon, m_ovf;

  bit tog_lvl, clr_lvl;

  function automatic logic [15:0] to_bcd(int n);
    return 16'((n / 1000 % 10) * 4096 + (n / 100 % 10) * 256 + (n / 10 % 10) * 16 + n % 10);
  endfunction

  function automatic logic [18:0] model_out();
    return {to_bcd(m_lapon ? m_lap : m_live), (m_st == M_RUN), m_lapon, m_ovf};
  endfunction

  function automatic logic [18:0] dut_out();
    return {sw.digits, sw.running, sw.lap_active, sw.overflow};
  endfunction

  task automatic check(input string name, input logic [18:0] got, input logic [18:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t: got digits=%h run=%b lap=%b ovf=%b, want digits=%h run=%b lap=%b ovf=%b",
               name, $time, got[18:3], got[2], got[1], got[0], want[18:3], want[2], want[1], want[0]);
    end
  endtask

  // One clock of the model: register state after the next rising edge.
  task automatic model_step(input bit t, input bit c, input bit r);
    bit te, ce;
    int old_st, old_live;
    if (r) begin
      m_st = M_IDLE; m_pre = 0; m_live = 0; m_lap = 0;
      m_armed = 0; m_tq = 0; m_cq = 0; m_lapon = 0; m_ovf = 0;
      return;
    end
    if (!m_armed) begin
      m_armed = 1; m_tq = t; m_cq = c;
      return;
    end
    te = (t != m_tq);
    ce = c && !m_cq && !te;
    m_tq = t; m_cq = c;
    old_st = m_st; old_live = m_live;
    if (old_st == M_RUN && !te) begin
      if (m_pre == DIV - 1) begin
        m_pre = 0;
        m_live = (m_live + 1) % 10000;
        if (m_live == 0) m_ovf = 1;
      end else begin
        m_pre++;
      end
    end
    if (te) begin
      if (old_st == M_IDLE) begin m_st = M_RUN; m_pre = 0; end
      else if (old_st == M_RUN) m_st = M_PAUSED;
      else m_st = M_RUN;
    end else if (ce) begin
      if (old_st == M_RUN) begin
        if (m_lapon) m_lapon = 0;
        else begin m_lap = old_live; m_lapon = 1; end
      end else if (old_st == M_PAUSED) begin
        if (m_lapon) m_lapon = 0;
        else begin m_live = 0; m_pre = 0; m_ovf = 0; m_st = M_IDLE; end
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the expected result.
  task automatic step(input bit r);
    bit prev_r;
    @(negedge clk_1kHz);
    prev_r = rst;
    sw.btn_toggle = tog_lvl;
    sw.btn_clr = clr_lvl;
    rst = r;
    model_step(tog_lvl, clr_lvl, r);
    if (r && !prev_r) begin
      #1;
      check("async_rst", dut_out(), 19'd0);
    end
    exp_q.push_back(model_out());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic flip();
    tog_lvl = ~tog_lvl;
    step(1'b0);
  endtask

  task automatic pulse_clr();
    clr_lvl = 1'b1;
    step(1'b0);
    clr_lvl = 1'b0;
    step(1'b0);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(posedge clk_1kHz) begin
    #1;
    if (exp_q.size() > 0) check("cycle", dut_out(), exp_q.pop_front());
  end

  initial begin
    tog_lvl = 1'b1;
    clr_lvl = 1'b0;
    sw.btn_toggle = 1'b1;
    sw.btn_clr = 1'b0;
    model_step(1'b1, 1'b0, 1'b1);

    // reset held with toggle high, then release: no spurious start
    for (int i = 0; i < 3; i++) step(1'b1);
    run(5);
    pulse_clr();              // clear in IDLE does nothing
    run(3);

    // start, count, pause, clear back to IDLE
    flip();
    run(100);
    flip();
    run(50);
    pulse_clr();
    run(3);

    // lap freeze and release while running, lap cleared while paused
    flip();
    run(40);
    pulse_clr();
    run(30);
    pulse_clr();
    run(10);
    pulse_clr();
    run(5);
    flip();
    pulse_clr();              // drops lap only
    run(4);
    pulse_clr();              // clears count, back to IDLE
    run(3);

    // randomized button activity
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) tog_lvl = ~tog_lvl;
      if ($urandom_range(9) == 0) clr_lvl = ~clr_lvl;
      step(1'b0);
    end

    // known state again
    clr_lvl = 1'b0;
    step(1'b1);
    step(1'b1);
    run(2);

    // simultaneous toggle and clear rising edge while running: toggle wins
    flip();
    run(20);
    tog_lvl = ~tog_lvl;
    clr_lvl = 1'b1;
    step(1'b0);
    run(5);
    clr_lvl = 1'b0;
    run(2);
    flip();                   // resume
    run(7);
    flip();                   // pause
    pulse_clr();              // clear to IDLE
    run(2);

    // run through 99.99 -> 00.00, then pause and clear the sticky overflow
    flip();
    run(10000 * DIV + 20);
    flip();
    run(3);
    pulse_clr();
    run(3);

    // reset in the middle of a run, then release
    flip();
    run(30);
    step(1'b1);
    step(1'b1);
    run(5);

    repeat (3) @(negedge clk_1kHz);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
